fetch_hazard_ctrl: RTL and testbench
====================================

Name: fetch_hazard_ctrl

Overview:
- Front-end pipeline controller; sequences the PC register and the IF/ID pipeline register.
- Drives stall, flush and redirect for the PC and IF/ID register.
- Supplies the IF-stage branch prediction (if_take) from a BHT of 2-bit saturating counters, trained at EX resolution.
- Detects load-use hazards and holds the front end for a configurable number of cycles via a small FSM.

Parameters:
- BHT_ENTRIES, 16, number of BHT counters; power of 2, min 2; index = if_pc[log2(BHT_ENTRIES)+1:2].
- LU_STALL_CYCLES, 1, front-end hold cycles per load-use hazard; range 1..7.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- if_pc  in  32  current fetch address.
- id_rs1  in  5  ID-stage source register 1.
- id_rs2  in  5  ID-stage source register 2.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- id_jump  in  1  ID instruction is an unconditional jump.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd  in  5  EX destination register.
- ex_branch  in  1  EX holds a resolved conditional branch.
- ex_taken  in  1  actual branch outcome.
- ex_pred_taken  in  1  prediction carried with that branch.
- ex_pc  in  32  address of the EX branch.
- if_take  out  1  prediction for if_pc.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold IF/ID register.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_bubble  out  1  inject NOP into ID/EX.
- redirect_sel  out  2  next PC: 0 sequential/predicted, 1 EX branch target, 2 EX fall-through (ex_pc+4), 3 ID jump target.
- mispredict_cnt  out  16  saturating mispredict count.

Behaviour:
- Reset (async): state=RUN, stall counter=0, all BHT entries=2'b01 (weakly not-taken), mispredict_cnt=0.
- Outputs at reset: all control outputs 0; redirect_sel=0; if_take=bht[idx][1]=0.
- mispredict = ex_branch && (ex_taken != ex_pred_taken).
- load_use = ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
- Event priority, combinational, same cycle: mispredict > stall/load_use > id_jump.
- mispredict:
  - if_id_flush=1, id_ex_bubble=1, pc_stall=0, if_id_stall=0.
  - redirect_sel = ex_taken ? 1 : 2.
  - Next state RUN (aborts any STALL); counter cleared.
- FSM states RUN, STALL.
  - RUN, load_use, no mispredict: pc_stall=if_id_stall=id_ex_bubble=1 this cycle. If LU_STALL_CYCLES>1, go to STALL with counter=LU_STALL_CYCLES-1; else stay RUN.
  - STALL: pc_stall=if_id_stall=id_ex_bubble=1; counter decrements each cycle; return to RUN when the counter reaches 0 at the clock edge. Total hold = LU_STALL_CYCLES cycles.
  - Load-use is not re-evaluated inside STALL.
- id_jump in RUN with no load_use/mispredict: if_id_flush=1, redirect_sel=3, no stall.
- id_jump coincident with load_use: stall wins; the jump is honoured after the stall releases.
- if_take = bht[if_pc index][1], independent of state.
- BHT update on every clock edge with ex_branch=1, regardless of mispredict or state:
  - ex_taken=1: counter+1, saturate at 3.
  - ex_taken=0: counter-1, saturate at 0.
  - Index from ex_pc[log2(BHT_ENTRIES)+1:2].
- mispredict_cnt increments on each edge where mispredict=1; saturates at 16'hFFFF.
- Reset asserted mid-stall: immediate return to RUN; all outputs 0 while reset is high.

Optional Feature:
- Macro BHT_BYPASS_EN.
- Defined: if ex_branch updates the same index if_pc reads in the same cycle, if_take reflects the post-update counter MSB (combinational bypass).
- Undefined: if_take reflects the stored (pre-update) value; the new value is visible from the next cycle.

Test Plan:
- Reset, then idle -> all control outputs 0; if_take=0 for if_pc=0x0,0x4,...,0x3C.
- ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1, LU_STALL_CYCLES=2 -> pc_stall/if_id_stall/id_ex_bubble=1 for exactly 2 cycles, then 0.
- Same hazard but ex_rd=0 -> no stall.
- ex_branch=1, ex_taken=1, ex_pred_taken=0 -> if_id_flush=1, id_ex_bubble=1, redirect_sel=1; mispredict_cnt 0->1.
- Same with ex_taken=0, ex_pred_taken=1 -> redirect_sel=2.
- Three taken resolutions at ex_pc=0x10 (BHT_ENTRIES=16) -> counter 01->10->11->11; if_take=1 for if_pc=0x10 after the first update.
- Same-cycle update and read at index 4 from 01, taken -> if_take=1 same cycle with BHT_BYPASS_EN, 0 without (1 next cycle).
- Mispredict coincident with load_use in STALL -> flush/redirect only, pc_stall=0, FSM back to RUN; id_jump with load_use -> stall first, redirect_sel=3 after release.

Source files
------------

// File: rtl/fetch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_hazard_ctrl
// Brief    : Front-end stall/flush/redirect control with a 2-bit BHT predictor
//            and a load-use hold FSM. Optional macro BHT_BYPASS_EN forwards a
//            same-cycle BHT update to if_take.
// Revision : 1.0
// ============================================================================
module fetch_hazard_ctrl #(
    parameter int BHT_ENTRIES     = 16,
    parameter int LU_STALL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_pc,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        id_jump,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch,
    input  logic        ex_taken,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pc,
    output logic        if_take,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic [1:0]  redirect_sel,
    output logic [15:0] mispredict_cnt
);

    localparam int          c_IDX_W   = $clog2(BHT_ENTRIES);
    localparam int          c_CNT_W   = 3;
    localparam logic [2:0]  c_LU_INIT = 3'(LU_STALL_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [1:0]           r_bht [BHT_ENTRIES];
    logic [15:0]          r_mp_cnt;

    logic [c_IDX_W-1:0]   w_rd_idx, w_wr_idx;
    logic [1:0]           w_wr_cur, w_wr_val;
    logic                 w_mispredict, w_load_use, w_take;
    logic                 w_stall, w_flush, w_bubble;
    logic [1:0]           w_redir;
    logic                 w_unused_bits;

    assign w_rd_idx = if_pc[c_IDX_W+1:2];
    assign w_wr_idx = ex_pc[c_IDX_W+1:2];
    assign w_unused_bits = ^{if_pc[31:c_IDX_W+2], if_pc[1:0],
                             ex_pc[31:c_IDX_W+2], ex_pc[1:0]};

    assign w_mispredict = ex_branch && (ex_taken != ex_pred_taken);
    assign w_load_use   = ex_mem_read && (ex_rd != 5'd0) &&
                          ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                           (id_uses_rs2 && (id_rs2 == ex_rd)));

    // Saturating 2-bit counter step for the entry being trained
    assign w_wr_cur = r_bht[w_wr_idx];
    always_comb begin
        w_wr_val = w_wr_cur;
        if (ex_taken) begin
            if (w_wr_cur != 2'b11) w_wr_val = w_wr_cur + 2'b01;
        end else begin
            if (w_wr_cur != 2'b00) w_wr_val = w_wr_cur - 2'b01;
        end
    end

    always_comb begin
        w_take = r_bht[w_rd_idx][1];
`ifdef BHT_BYPASS_EN
        if (ex_branch && (w_wr_idx == w_rd_idx)) w_take = w_wr_val[1];
`endif
    end

    // Priority: mispredict, then stall (FSM hold or new load-use), then jump
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_flush     = 1'b0;
        w_bubble    = 1'b0;
        w_redir     = 2'd0;
        if (w_mispredict) begin
            w_flush     = 1'b1;
            w_bubble    = 1'b1;
            w_redir     = ex_taken ? 2'd1 : 2'd2;
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
        end else if (r_state == ST_STALL) begin
            w_stall   = 1'b1;
            w_bubble  = 1'b1;
            w_cnt_nxt = r_cnt - 3'd1;
            if (r_cnt == 3'd1) w_state_nxt = ST_RUN;
        end else if (w_load_use) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
            if (LU_STALL_CYCLES > 1) begin
                w_state_nxt = ST_STALL;
                w_cnt_nxt   = c_LU_INIT;
            end
        end else if (id_jump) begin
            w_flush = 1'b1;
            w_redir = 2'd3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
        end else if (ex_branch) begin
            r_bht[w_wr_idx] <= w_wr_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mp_cnt <= '0;
        end else if (w_mispredict && (r_mp_cnt != 16'hFFFF)) begin
            r_mp_cnt <= r_mp_cnt + 16'd1;
        end
    end

    // Outputs are forced quiet for as long as reset is held
    assign if_take        = w_take   & ~reset;
    assign pc_stall       = w_stall  & ~reset;
    assign if_id_stall    = w_stall  & ~reset;
    assign if_id_flush    = w_flush  & ~reset;
    assign id_ex_bubble   = w_bubble & ~reset;
    assign redirect_sel   = reset ? 2'd0 : w_redir;
    assign mispredict_cnt = r_mp_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_hazard_ctrl
// Brief    : Directed table-driven bench for fetch_hazard_ctrl (LU=2 and LU=3).
// Revision : 1.0
// ============================================================================
module tb_fetch_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc, ex_pc;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, id_jump, ex_mem_read;
    logic        ex_branch, ex_taken, ex_pred_taken;
    logic        if_take, pc_stall, if_id_stall, if_id_flush, id_ex_bubble;
    logic [1:0]  redirect_sel;
    logic [15:0] mispredict_cnt;
    logic        if_take3, pc_stall3, if_id_stall3, if_id_flush3, id_ex_bubble3;
    logic [1:0]  redirect_sel3;
    logic [15:0] mispredict_cnt3;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fetch_hazard_ctrl #(.BHT_ENTRIES(16), .LU_STALL_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch(ex_branch), .ex_taken(ex_taken),
        .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc),
        .if_take(if_take), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .redirect_sel(redirect_sel), .mispredict_cnt(mispredict_cnt)
    );

    fetch_hazard_ctrl #(.BHT_ENTRIES(16), .LU_STALL_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch(ex_branch), .ex_taken(ex_taken),
        .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc),
        .if_take(if_take3), .pc_stall(pc_stall3), .if_id_stall(if_id_stall3),
        .if_id_flush(if_id_flush3), .id_ex_bubble(id_ex_bubble3),
        .redirect_sel(redirect_sel3), .mispredict_cnt(mispredict_cnt3)
    );

    typedef struct {
        logic       mr;
        logic [4:0] rd, rs1, rs2;
        logic       u1, u2, jmp, br, tk, pt;
        logic       e_stall, e_flush, e_bubble;
        logic [1:0] e_redir;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_jump = 0;
        ex_mem_read = 0; ex_rd = 0; ex_branch = 0; ex_taken = 0; ex_pred_taken = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctrl(input string name, input logic st, input logic fl,
                            input logic bb, input logic [1:0] rs);
        chk({name, ".pc_stall"},     {31'd0, pc_stall},     {31'd0, st});
        chk({name, ".if_id_stall"},  {31'd0, if_id_stall},  {31'd0, st});
        chk({name, ".if_id_flush"},  {31'd0, if_id_flush},  {31'd0, fl});
        chk({name, ".id_ex_bubble"}, {31'd0, id_ex_bubble}, {31'd0, bb});
        chk({name, ".redirect_sel"}, {30'd0, redirect_sel}, {30'd0, rs});
    endtask

    task automatic set_lu();
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    endtask

    initial begin
        // mr rd rs1 rs2 u1 u2 jmp br tk pt | stall flush bubble redir
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0};
        tbl[1]  = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 2'd3};
        tbl[3]  = '{1, 7, 1, 7, 0, 1, 0, 0, 0, 0, 1, 0, 1, 2'd0};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'd0};
        tbl[5]  = '{1, 9, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 2'd1};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 2'd2};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 2'd0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 1, 2'd2};
        tbl[10] = '{1, 3, 3, 0, 1, 0, 0, 1, 1, 0, 0, 1, 1, 2'd1};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0};

        idle();
        if_pc = 0; ex_pc = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        set_lu(); id_jump = 1;
        #1;
        chk_ctrl("in_reset", 0, 0, 0, 2'd0);
        chk("in_reset.cnt", {16'd0, mispredict_cnt}, 32'd0);
        idle();
        reset = 0;

        // Reset BHT: every entry weakly not-taken
        tick();
        chk_ctrl("idle", 0, 0, 0, 2'd0);
        for (int i = 0; i < 16; i++) begin
            if_pc = 32'(i * 4);
            #1;
            chk($sformatf("reset_take_pc%0h", i * 4), {31'd0, if_take}, 32'd0);
        end

        // Same-cycle update and read at index 4
        if_pc = 32'h10; ex_pc = 32'h10;
        ex_branch = 1; ex_taken = 1; ex_pred_taken = 1;
        #1;
`ifdef BHT_BYPASS_EN
        chk("bypass_same_cycle", {31'd0, if_take}, 32'd1);
`else
        chk("bypass_same_cycle", {31'd0, if_take}, 32'd0);
`endif
        tick();
        ex_branch = 0;
        #1;
        chk("train1_take", {31'd0, if_take}, 32'd1);
        ex_branch = 1;
        tick();
        tick();
        ex_branch = 0;
        #1;
        chk("train3_sat_take", {31'd0, if_take}, 32'd1);
        ex_branch = 1; ex_taken = 0; ex_pred_taken = 0;
        tick();
        ex_branch = 0;
        #1;
        chk("untrain1_take", {31'd0, if_take}, 32'd1);
        ex_branch = 1;
        tick();
        ex_branch = 0;
        #1;
        chk("untrain2_take", {31'd0, if_take}, 32'd0);
        chk("no_mp_cnt", {16'd0, mispredict_cnt}, 32'd0);

        // Load-use hold: 2 cycles for LU=2, 3 cycles for LU=3
        if_pc = 32'h20; ex_pc = 32'h100;
        tick();
        set_lu();
        #1;
        chk_ctrl("lu_c1", 1, 0, 1, 2'd0);
        chk("lu3_c1", {31'd0, pc_stall3}, 32'd1);
        tick();
        idle();
        #1;
        chk_ctrl("lu_c2", 1, 0, 1, 2'd0);
        chk("lu3_c2", {31'd0, pc_stall3}, 32'd1);
        tick();
        #1;
        chk_ctrl("lu_c3", 0, 0, 0, 2'd0);
        chk("lu3_c3", {31'd0, pc_stall3}, 32'd1);
        tick();
        #1;
        chk("lu3_c4", {31'd0, pc_stall3}, 32'd0);

        // Zero destination never hazards
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
        #1;
        chk_ctrl("lu_rd0", 0, 0, 0, 2'd0);
        idle();

        // Jump coincident with load-use: stall first, jump after release
        repeat (2) tick();
        set_lu(); id_jump = 1;
        #1;
        chk_ctrl("jlu_c1", 1, 0, 1, 2'd0);
        tick();
        ex_mem_read = 0;
        #1;
        chk_ctrl("jlu_c2", 1, 0, 1, 2'd0);
        tick();
        #1;
        chk_ctrl("jlu_c3", 0, 1, 0, 2'd3);
        idle();
        repeat (2) tick();

        for (int v = 0; v < 12; v++) begin
            tick();
            ex_mem_read = tbl[v].mr; ex_rd = tbl[v].rd;
            id_rs1 = tbl[v].rs1; id_rs2 = tbl[v].rs2;
            id_uses_rs1 = tbl[v].u1; id_uses_rs2 = tbl[v].u2;
            id_jump = tbl[v].jmp; ex_branch = tbl[v].br;
            ex_taken = tbl[v].tk; ex_pred_taken = tbl[v].pt;
            #2;
            chk_ctrl($sformatf("vec%0d", v), tbl[v].e_stall, tbl[v].e_flush,
                     tbl[v].e_bubble, tbl[v].e_redir);
        end
        tick();
        idle();
        #1;
        chk("table_mp_cnt", {16'd0, mispredict_cnt}, 32'd4);
        if_pc = 32'h0;
        #1;
        chk("idx0_take", {31'd0, if_take}, 32'd1);
        if_pc = 32'h20;

        // Mispredict inside STALL aborts the hold
        repeat (3) tick();
        set_lu();
        #1;
        chk("mps_c1", {31'd0, pc_stall3}, 32'd1);
        tick();
        ex_branch = 1; ex_taken = 1; ex_pred_taken = 0;
        #1;
        chk_ctrl("mps_c2", 0, 1, 1, 2'd1);
        chk("mps3_c2_stall", {31'd0, pc_stall3}, 32'd0);
        chk("mps3_c2_redir", {30'd0, redirect_sel3}, 32'd1);
        tick();
        idle();
        #1;
        chk("mps3_c3_stall", {31'd0, pc_stall3}, 32'd0);
        chk("mps_cnt", {16'd0, mispredict_cnt}, 32'd5);

        // Reset asserted mid-stall
        tick();
        set_lu();
        #1;
        chk("rst_mid_c1", {31'd0, pc_stall3}, 32'd1);
        tick();
        #2;
        reset = 1;
        #1;
        chk_ctrl("rst_mid", 0, 0, 0, 2'd0);
        chk("rst_mid_cnt", {16'd0, mispredict_cnt}, 32'd0);
        idle();
        tick();
        reset = 0;
        tick();
        #1;
        chk_ctrl("after_rst", 0, 0, 0, 2'd0);
        chk("after_rst3", {31'd0, pc_stall3}, 32'd0);
        if_pc = 32'h0;
        #1;
        chk("after_rst_take", {31'd0, if_take}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
